// File: rtl/pingpong_sched_pkg.sv
// Shared types and helpers for the ping-pong read scheduler.
package pingpong_sched_pkg;

  localparam int unsigned MAX_REQ   = 8;
  localparam int unsigned MAX_IDX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

  // Index of the set bit of a one-hot vector (0 when empty).
  function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = MAX_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or above the pointer, with wrap.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]                         req_i,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr_i,
  output logic [N-1:0]                         gnt_o,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] idx_o,
  output logic                                 any_o
);

  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [IDX_W-1:0] k;

  // Walk from the pointer upward; first hit wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    k     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      k = IDX_W'((32'(ptr_i) + i) % N);
      if (!any_o && req_i[k]) begin
        any_o    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = k;
      end
    end
  end

endmodule

// File: rtl/pingpong_read_scheduler.sv
// Hands whole ping-pong frames to one of N_REQ consumers in round-robin order,
// or drains and drops a frame when nobody is asking for it.
module pingpong_read_scheduler
  import pingpong_sched_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned N_REQ = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             buf_frame_i,
  input  logic [WIDTH-1:0] buf_data_i,
  input  logic             buf_valid_i,
  output logic             buf_ready_o,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] gnt_o,
  input  logic [N_REQ-1:0] rdy_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             last_o,
  output logic             frame_done_o,
  output logic             drop_o,
  output logic             overrun_o,
  output logic [CNT_W-1:0] drop_cnt_o
);

  localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned BEAT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_REQ - 1);

  state_e             state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic               pend_q;
  logic [BEAT_W-1:0]  beat_q;
  logic [N_REQ-1:0]   gnt_q;
  logic               done_q;
  logic               drop_q;
  logic               ovr_q;
  logic [CNT_W-1:0]   drop_cnt_q;

  logic [N_REQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic [IDX_W-1:0]   gnt_idx;
  logic               beat_c;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // Read handshake and stream qualifiers, decoded from the current state.
  always_comb begin
    buf_ready_o = 1'b0;
    valid_o     = 1'b0;
    last_o      = 1'b0;
    gnt_idx     = IDX_W'(onehot_to_idx(MAX_REQ'(gnt_q)));
    case (state_q)
      ST_STREAM: begin
        buf_ready_o = rdy_i[gnt_idx];
        valid_o     = buf_valid_i;
        last_o      = buf_valid_i && (beat_q == LAST_BEAT);
      end
      ST_DRAIN: buf_ready_o = 1'b1;
      default: ;
    endcase
    beat_c = buf_valid_i && buf_ready_o;
  end

  // Frame FSM, pending flag, beat counter and registered pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      pend_q     <= 1'b0;
      beat_q     <= '0;
      gnt_q      <= '0;
      done_q     <= 1'b0;
      drop_q     <= 1'b0;
      ovr_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      drop_q <= 1'b0;
      ovr_q  <= buf_frame_i && pend_q;
      case (state_q)
        ST_IDLE: begin
          // One frame is consumed here; a second simultaneous one stays pending.
          pend_q <= pend_q && buf_frame_i;
          if (buf_frame_i || pend_q) begin
            if (arb_any) begin
              gnt_q   <= arb_gnt;
              ptr_q   <= (arb_idx == LAST_IDX) ? '0 : arb_idx + IDX_W'(1);
              state_q <= ST_STREAM;
            end else begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_STREAM: begin
          pend_q <= pend_q || buf_frame_i;
          if (beat_c) begin
            if (beat_q == LAST_BEAT) begin
              beat_q  <= '0;
              gnt_q   <= '0;
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              beat_q <= beat_q + BEAT_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          pend_q <= pend_q || buf_frame_i;
          if (beat_c) begin
            if (beat_q == LAST_BEAT) begin
              beat_q  <= '0;
              drop_q  <= 1'b1;
              state_q <= ST_IDLE;
              if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
            end else begin
              beat_q <= beat_q + BEAT_W'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign data_o       = buf_data_i;
  assign gnt_o        = gnt_q;
  assign frame_done_o = done_q;
  assign drop_o       = drop_q;
  assign overrun_o    = ovr_q;
  assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_pingpong_read_scheduler.sv
// Directed bench for pingpong_read_scheduler with DEPTH=4, N_REQ=4.
module tb_pingpong_read_scheduler;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned N_REQ = 4;
  localparam int unsigned CNT_W = 16;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             buf_frame_i;
  logic [WIDTH-1:0] buf_data_i;
  logic             buf_valid_i;
  logic             buf_ready_o;
  logic [N_REQ-1:0] req_i;
  logic [N_REQ-1:0] gnt_o;
  logic [N_REQ-1:0] rdy_i;
  logic [WIDTH-1:0] data_o;
  logic             valid_o;
  logic             last_o;
  logic             frame_done_o;
  logic             drop_o;
  logic             overrun_o;
  logic [CNT_W-1:0] drop_cnt_o;

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct {
    logic        frame;
    logic        valid;
    logic [31:0] data;
    logic [3:0]  req;
    logic [3:0]  rdy;
    logic [3:0]  e_gnt;
    logic        e_val;
    logic        e_last;
    logic        e_brdy;
    logic        e_done;
    logic        e_drop;
    logic [15:0] e_dcnt;
  } vec_t;

  vec_t vq[$];

  always #5 clk_i = ~clk_i;

  pingpong_read_scheduler #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .N_REQ(N_REQ), .CNT_W(CNT_W)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .buf_frame_i  (buf_frame_i),
    .buf_data_i   (buf_data_i),
    .buf_valid_i  (buf_valid_i),
    .buf_ready_o  (buf_ready_o),
    .req_i        (req_i),
    .gnt_o        (gnt_o),
    .rdy_i        (rdy_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .last_o       (last_o),
    .frame_done_o (frame_done_o),
    .drop_o       (drop_o),
    .overrun_o    (overrun_o),
    .drop_cnt_o   (drop_cnt_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Apply inputs just after a rising edge and settle to mid-cycle.
  task automatic cyc(input logic fr, input logic vl, input logic [31:0] d,
                     input logic [3:0] rq, input logic [3:0] rd);
    buf_frame_i = fr;
    buf_valid_i = vl;
    buf_data_i  = d;
    req_i       = rq;
    rdy_i       = rd;
    #3;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic fr, input logic vl, input logic [31:0] d,
                      input logic [3:0] rq, input logic [3:0] rd, input logic [3:0] g,
                      input logic v, input logic l, input logic br, input logic dn,
                      input logic dp, input logic [15:0] dc);
    vec_t x;
    x.frame = fr; x.valid = vl; x.data = d; x.req = rq; x.rdy = rd;
    x.e_gnt = g; x.e_val = v; x.e_last = l; x.e_brdy = br;
    x.e_done = dn; x.e_drop = dp; x.e_dcnt = dc;
    vq.push_back(x);
  endtask

  initial begin
    logic [3:0] rdy_t;
    logic [3:0] req_t;
    int         seen;
    logic       bt;
    logic [3:0] one_hot;

    // Four granted frames, 8 cycles apart, round-robin 0..3.
    for (int k = 0; k < 4; k++) begin
      one_hot = 4'b0001 << k;
      for (int c = 0; c < 8; c++) begin
        bt = (c >= 1 && c <= 4);
        push(c == 0, bt, 32'h100 * (k + 1) + 32'(c), 4'hf, 4'hf,
             bt ? one_hot : 4'h0, bt, c == 4, bt, c == 5, 1'b0, 16'd0);
      end
    end
    // No requester: frame is drained and dropped.
    for (int c = 0; c < 8; c++) begin
      bt = (c >= 1 && c <= 4);
      push(c == 0, bt, 32'hD00 + 32'(c), 4'h0, 4'hf,
           4'h0, 1'b0, 1'b0, bt, 1'b0, c == 5, (c >= 5) ? 16'd1 : 16'd0);
    end

    // Reset state.
    rst_ni = 1'b0;
    cyc(1'b0, 1'b0, 32'h0, 4'h0, 4'h0);
    repeat (2) tick();
    #3;
    chk("rst_gnt", 32'(gnt_o), 32'h0);
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk("rst_bufrdy", 32'(buf_ready_o), 32'h0);
    chk("rst_pulses", {29'h0, frame_done_o, drop_o, overrun_o}, 32'h0);
    chk("rst_dcnt", 32'(drop_cnt_o), 32'h0);
    tick();
    rst_ni = 1'b1;

    // Table-driven section.
    foreach (vq[i]) begin
      cyc(vq[i].frame, vq[i].valid, vq[i].data, vq[i].req, vq[i].rdy);
      chk($sformatf("v%0d_gnt", i), 32'(gnt_o), 32'(vq[i].e_gnt));
      chk($sformatf("v%0d_valid", i), 32'(valid_o), 32'(vq[i].e_val));
      chk($sformatf("v%0d_last", i), 32'(last_o), 32'(vq[i].e_last));
      chk($sformatf("v%0d_bufrdy", i), 32'(buf_ready_o), 32'(vq[i].e_brdy));
      chk($sformatf("v%0d_done", i), 32'(frame_done_o), 32'(vq[i].e_done));
      chk($sformatf("v%0d_drop", i), 32'(drop_o), 32'(vq[i].e_drop));
      chk($sformatf("v%0d_dcnt", i), 32'(drop_cnt_o), 32'(vq[i].e_dcnt));
      chk($sformatf("v%0d_ovr", i), 32'(overrun_o), 32'h0);
      if (vq[i].e_val) chk($sformatf("v%0d_data", i), data_o, vq[i].data);
      tick();
    end

    // A: grantee toggles ready; four transfers, in order, last on the fourth.
    cyc(1'b1, 1'b0, 32'h0, 4'hf, 4'hf);
    tick();
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      rdy_t = (c % 2 == 0) ? 4'hf : 4'he;
      cyc(1'b0, 1'b1, 32'hA0 + 32'(seen), 4'hf, rdy_t);
      if (c < 7) begin
        chk("A_gnt", 32'(gnt_o), 32'h1);
        chk("A_valid", 32'(valid_o), 32'h1);
        chk("A_bufrdy", 32'(buf_ready_o), 32'(rdy_t[0]));
        chk("A_done", 32'(frame_done_o), 32'h0);
        if (rdy_t[0]) begin
          chk("A_data", data_o, 32'hA0 + 32'(seen));
          chk("A_last", 32'(last_o), 32'(seen == 3));
          seen++;
        end
      end else begin
        chk("A_done_end", 32'(frame_done_o), 32'h1);
        chk("A_gnt_end", 32'(gnt_o), 32'h0);
        chk("A_valid_end", 32'(valid_o), 32'h0);
      end
      tick();
    end
    chk("A_xfers", 32'(seen), 32'd4);

    // B: pulse during STREAM goes pending; a second one overruns.
    for (int c = 0; c < 13; c++) begin
      bt = (c >= 1 && c <= 4) || (c >= 6 && c <= 9);
      cyc(c == 0 || c == 2 || c == 3, bt, 32'hB0 + 32'(c), 4'hf, 4'hf);
      one_hot = (c >= 1 && c <= 4) ? 4'b0010 : (c >= 6 && c <= 9) ? 4'b0100 : 4'b0000;
      chk($sformatf("B%0d_gnt", c), 32'(gnt_o), 32'(one_hot));
      chk($sformatf("B%0d_valid", c), 32'(valid_o), 32'(bt));
      chk($sformatf("B%0d_last", c), 32'(last_o), 32'(c == 4 || c == 9));
      chk($sformatf("B%0d_done", c), 32'(frame_done_o), 32'(c == 5 || c == 10));
      chk($sformatf("B%0d_ovr", c), 32'(overrun_o), 32'(c == 4));
      tick();
    end

    // C: grantee drops its request mid-frame; no preemption.
    for (int c = 0; c < 6; c++) begin
      bt = (c >= 1 && c <= 4);
      req_t = (c >= 2) ? 4'b0111 : 4'b1111;
      cyc(c == 0, bt, 32'hC0 + 32'(c), req_t, 4'hf);
      chk($sformatf("C%0d_gnt", c), 32'(gnt_o), bt ? 32'h8 : 32'h0);
      chk($sformatf("C%0d_last", c), 32'(last_o), 32'(c == 4));
      chk($sformatf("C%0d_done", c), 32'(frame_done_o), 32'(c == 5));
      chk($sformatf("C%0d_dcnt", c), 32'(drop_cnt_o), 32'd1);
      tick();
    end

    // D: reset at beat 2 of a frame granted to requester 0 (pointer now 1).
    for (int c = 0; c < 3; c++) begin
      cyc(c == 0, c >= 1, 32'hE0 + 32'(c), 4'hf, 4'hf);
      if (c >= 1) chk($sformatf("D%0d_gnt", c), 32'(gnt_o), 32'h1);
      tick();
    end
    buf_valid_i = 1'b1;
    #1;
    rst_ni = 1'b0;
    #2;
    chk("D_rst_gnt", 32'(gnt_o), 32'h0);
    chk("D_rst_valid", 32'(valid_o), 32'h0);
    chk("D_rst_last", 32'(last_o), 32'h0);
    chk("D_rst_bufrdy", 32'(buf_ready_o), 32'h0);
    chk("D_rst_dcnt", 32'(drop_cnt_o), 32'h0);
    tick();
    rst_ni = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bt = (c >= 1 && c <= 4);
      cyc(c == 0, bt, 32'hF0 + 32'(c), 4'hf, 4'hf);
      chk($sformatf("D%0d_post_gnt", c), 32'(gnt_o), bt ? 32'h1 : 32'h0);
      chk($sformatf("D%0d_post_last", c), 32'(last_o), 32'(c == 4));
      chk($sformatf("D%0d_post_done", c), 32'(frame_done_o), 32'(c == 5));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/pingpong_read_scheduler.md
# pingpong_read_scheduler

- Shares the read port of the ping-pong buffer RAM controller among N_REQ consumers, one complete frame at a time.
- Waits for the controller's buffer-ready pulse, then grants the frame to a requester chosen round-robin and streams exactly DEPTH beats to it. When nobody is requesting, it drains and drops the frame.
- Sits between the ping-pong buffer's read interface and the downstream processing blocks.

## Interface
- WIDTH, 32, data width; must match the buffer.
- DEPTH, 256, beats per frame; must match the buffer.
- N_REQ, 4, number of consumers, 2..8.
- CNT_W, 16, width of the drop counter.
- clk_i  in  1  clock; the block uses one clock.
- rst_ni  in  1  reset; asynchronous assert, active-low.
- buf_frame_i  in  1  one-cycle pulse: a full buffer is ready to read.
- buf_data_i  in  WIDTH  read data from the buffer.
- buf_valid_i  in  1  buffer read data valid.
- buf_ready_o  out  1  read-ready to the buffer.
- req_i  in  N_REQ  per-consumer frame request (level).
- gnt_o  out  N_REQ  one-hot frame grant (registered).
- rdy_i  in  N_REQ  per-consumer ready.
- data_o  out  WIDTH  stream data, shared by all consumers.
- valid_o  out  1  stream valid; meaningful to the granted consumer only.
- last_o  out  1  marks the final beat of the frame.
- frame_done_o  out  1  one-cycle pulse: the granted frame has completed.
- drop_o  out  1  one-cycle pulse: a frame was drained with no consumer.
- overrun_o  out  1  one-cycle pulse: a frame pulse arrived while one was already pending.
- drop_cnt_o  out  CNT_W  count of dropped frames, saturating.

## Operation
- States: IDLE, STREAM, DRAIN.
- Reset values: state IDLE; round-robin pointer 0; pending flag 0; beat counter 0; gnt_o 0; all pulse outputs 0; drop_cnt_o 0.
- Pending flag:
  - Set by buf_frame_i in any state.
  - Cleared when IDLE consumes it.
  - If buf_frame_i arrives while pending is already 1, overrun_o pulses and the flag stays at 1. Frames are never queued deeper than one.
- IDLE: when (buf_frame_i OR pending) is true, arbitrate on the current req_i:
  - Winner = first set bit searching from the pointer upward, with wrap-around.
  - On a win: gnt_o gets the winner's one-hot bit, the pointer becomes (winner+1) mod N_REQ, and the state goes to STREAM.
  - With req_i == 0: the state goes to DRAIN and the pointer is unchanged.
- STREAM:
  - buf_ready_o = rdy_i[granted].
  - valid_o = buf_valid_i; data_o = buf_data_i (combinational pass-through).
  - A beat transfers when buf_valid_i && rdy_i[granted].
  - The beat counter increments per beat. last_o = valid_o && (count == DEPTH-1).
  - On the last beat: the counter goes to 0, the state goes to IDLE, and the next cycle has frame_done_o = 1 and gnt_o = 0.
  - There is no preemption: if req_i of the grantee drops mid-frame, the grant holds until the frame ends.
- DRAIN:
  - buf_ready_o = 1; valid_o = 0; gnt_o = 0.
  - Beats are counted the same way as in STREAM.
  - After DEPTH beats the state returns to IDLE. drop_o pulses in the next cycle and drop_cnt_o increments, saturating at all-ones.
- Outside STREAM: valid_o = 0, last_o = 0, buf_ready_o = 0 (DRAIN excepted).
- Reset asserted mid-frame: all state clears at once. The buffer's partially read frame is the buffer's responsibility.

## Timing
- Latency from the buf_frame_i edge to the first beat:
  - gnt_o is registered, so it is high in cycle t+1 and the first beat can transfer in t+1.
  - A frame taken from the pending flag starts one cycle after IDLE is re-entered.
- Throughput: one beat per cycle when buf_valid_i and rdy_i are both high. A frame therefore occupies DEPTH cycles, plus one IDLE cycle between frames.
- buf_ready_o, valid_o and last_o are combinational from registered state and inputs. All pulses are registered and last exactly one cycle.
- Simultaneous buf_frame_i and the last beat: the pending flag is set, and the next frame starts from IDLE one cycle later.

## Structure
- Package pingpong_sched_pkg holds the state enum (IDLE, STREAM, DRAIN) and a one-hot-to-index function.
- Sub-module rr_arbiter (parameter N), purely combinational:
  - Inputs: req, pointer. Outputs: one-hot grant, index, any.
  - The scheduler registers its result.

## Test plan
- Reset, then DEPTH=4, N_REQ=4, req_i=4'b1111, rdy all high. Four frame pulses spaced 8 cycles apart must produce grants 0001, 0010, 0100, 1000 in that order, each with 4 beats and last_o on beat 3.
- req_i=0 at the frame pulse: expect DRAIN with buf_ready_o=1 for 4 beats, gnt_o=0, then drop_o pulse and drop_cnt_o=1.
- Grantee toggles rdy_i 1,0,1,0: exactly 4 transfers occur, data order is preserved, and no beat is duplicated or skipped.
- Frame pulse during STREAM: pending is set, and the second frame starts one cycle after frame_done_o. A third pulse arriving before then gives overrun_o=1.
- Grantee drops req_i at beat 1: the grant holds and the frame completes all 4 beats.
- rst_ni asserted mid-STREAM at beat 2: gnt_o, valid_o and the counter are 0 immediately. After release, the next frame pulse starts at beat 0 with pointer 0.
